// File: rtl/fm_audio_pkg.sv
// Shared widths, AGC constants, state type and saturation helpers for the FM audio back-end.
package fm_audio_pkg;
    localparam int DW        = 12;
    localparam int GW        = 8;
    localparam int DC_SHIFT  = 10;
    localparam int ACC_W     = DW + DC_SHIFT + 1;
    localparam int BLOCK_LEN = 256;
    localparam int CNT_W     = $clog2(BLOCK_LEN);
    localparam int PEAK_W    = DW - 1;
    localparam int HOLD_W    = 3;

    localparam logic [GW-1:0]     GAIN_INIT   = 8'd16;
    localparam logic [GW-1:0]     GAIN_MIN    = 8'd4;
    localparam logic [GW-1:0]     GAIN_MAX    = 8'd255;
    localparam logic [PEAK_W-1:0] TARGET_HI   = 11'd1536;
    localparam logic [PEAK_W-1:0] TARGET_LO   = 11'd768;
    localparam logic [HOLD_W-1:0] HOLD_BLOCKS = 3'd4;

    localparam logic signed [31:0] SMAX = 32'sd2047;
    localparam logic signed [31:0] SMIN = -32'sd2048;

    typedef enum logic {TRACK = 1'b0, HOLD = 1'b1} agc_state_t;

    function automatic logic is_sat(input logic signed [31:0] x);
        return (x > SMAX) || (x < SMIN);
    endfunction

    function automatic logic signed [DW-1:0] sat_dw(input logic signed [31:0] x);
        logic signed [DW-1:0] r;
        if (x > SMAX) begin
            r = SMAX[DW-1:0];
        end else if (x < SMIN) begin
            r = SMIN[DW-1:0];
        end else begin
            r = x[DW-1:0];
        end
        return r;
    endfunction
endpackage

// File: rtl/fm_audio_agc_if.sv
// Sample stream in, gain-corrected audio and AGC status out.
interface fm_audio_agc_if;
    import fm_audio_pkg::*;
    logic signed [DW-1:0] din;
    logic                 din_valid;
    logic signed [DW-1:0] dout;
    logic                 dout_valid;
    logic [GW-1:0]        gain;
    logic                 clip;
    logic                 pwm_out;

    modport master (output din, din_valid, input dout, dout_valid, gain, clip, pwm_out);
    modport slave  (input din, din_valid, output dout, dout_valid, gain, clip, pwm_out);
endinterface

// File: rtl/fm_audio_sdm.sv
// First-order sigma-delta: the carry of a phase accumulator gives pulse density level/2^DW.
module fm_audio_sdm import fm_audio_pkg::*; (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] level,
    output logic          pwm
);
    logic [DW-1:0] acc_r;
    logic [DW:0]   sum_s;
    logic          pwm_r;

    assign sum_s = {1'b0, acc_r} + {1'b0, level};

    // Accumulate the level every clock; overflow is the output bit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_r <= '0;
            pwm_r <= 1'b0;
        end else begin
            acc_r <= sum_s[DW-1:0];
            pwm_r <= sum_s[DW];
        end
    end

    assign pwm = pwm_r;
endmodule

// File: rtl/fm_audio_agc.sv
// DC-blocking high-pass plus block-peak AGC for demodulated FM audio.
// Optional 1-bit DAC modulator enabled by FM_AUDIO_PWM_EN.
module fm_audio_agc import fm_audio_pkg::*; (
    input  logic          clk,
    input  logic          rst_n,
    fm_audio_agc_if.slave bus
);
    logic signed [ACC_W-1:0]   dc_acc_r;
    logic signed [ACC_W-1:0]   diff_s;
    logic signed [DW-1:0]      hp_r;
    logic                      hp_valid_r;
    logic signed [DW+GW:0]     prod_s;
    logic signed [DW+GW-4:0]   scaled_s;
    logic signed [DW-1:0]      dout_r;
    logic                      dout_valid_r;
    logic                      sat_s;
    logic                      clip_r;
    logic [PEAK_W-1:0]         mag_s;
    logic [PEAK_W-1:0]         peak_s;
    logic [PEAK_W-1:0]         peak_r;
    logic [CNT_W-1:0]          cnt_r;
    logic                      block_end_s;
    logic [GW-1:0]             gain_r;
    logic [GW-1:0]             gain_next_s;
    logic [GW-1:0]             half_s;
    logic [GW-1:0]             three_q_s;
    agc_state_t                state_r;
    agc_state_t                state_next_s;
    logic [HOLD_W-1:0]         hold_r;
    logic [HOLD_W-1:0]         hold_next_s;

    assign diff_s   = ACC_W'(bus.din) - (dc_acc_r >>> DC_SHIFT);
    assign prod_s   = (DW+GW+1)'(hp_r) * $signed({1'b0, gain_r});
    assign scaled_s = prod_s[DW+GW:4];
    assign sat_s    = hp_valid_r && is_sat(32'(scaled_s));

    // Stage 1: DC tracker and high-passed sample
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dc_acc_r   <= '0;
            hp_r       <= '0;
            hp_valid_r <= 1'b0;
        end else begin
            hp_valid_r <= bus.din_valid;
            if (bus.din_valid) begin
                dc_acc_r <= dc_acc_r + diff_s;
                hp_r     <= sat_dw(32'(diff_s));
            end else begin
                dc_acc_r <= dc_acc_r;
                hp_r     <= hp_r;
            end
        end
    end

    // Stage 2: apply gain with saturation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_r       <= '0;
            dout_valid_r <= 1'b0;
        end else begin
            dout_valid_r <= hp_valid_r;
            if (hp_valid_r) begin
                dout_r <= sat_dw(32'(scaled_s));
            end else begin
                dout_r <= dout_r;
            end
        end
    end

    // Magnitude of the output sample folded into the running block peak
    always_comb begin
        mag_s  = '0;
        peak_s = peak_r;
        if (dout_r[DW-1]) begin
            if (dout_r == SMIN[DW-1:0]) begin
                mag_s = SMAX[PEAK_W-1:0];
            end else begin
                mag_s = PEAK_W'(-dout_r);
            end
        end else begin
            mag_s = dout_r[PEAK_W-1:0];
        end
        if (dout_valid_r && (mag_s > peak_r)) begin
            peak_s = mag_s;
        end else begin
            peak_s = peak_r;
        end
    end

    assign block_end_s = dout_valid_r && (cnt_r == CNT_W'(BLOCK_LEN - 1));

    // Block statistics; a sample in stage 2 on the block-end edge opens the new block's clip
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            peak_r <= '0;
            cnt_r  <= '0;
            clip_r <= 1'b0;
        end else if (block_end_s) begin
            peak_r <= '0;
            cnt_r  <= '0;
            clip_r <= sat_s;
        end else begin
            peak_r <= peak_s;
            cnt_r  <= dout_valid_r ? cnt_r + CNT_W'(1) : cnt_r;
            clip_r <= clip_r | sat_s;
        end
    end

    // AGC state, hold counter and gain register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= TRACK;
            hold_r  <= '0;
            gain_r  <= GAIN_INIT;
        end else begin
            state_r <= state_next_s;
            hold_r  <= hold_next_s;
            gain_r  <= gain_next_s;
        end
    end

    assign half_s    = gain_r >> 1;
    assign three_q_s = gain_r - (gain_r >> 2);

    // Block-end gain decision: reductions always allowed, increases only while tracking
    always_comb begin
        state_next_s = state_r;
        hold_next_s  = hold_r;
        gain_next_s  = gain_r;
        if (block_end_s) begin
            if (clip_r) begin
                gain_next_s  = (half_s < GAIN_MIN) ? GAIN_MIN : half_s;
                state_next_s = HOLD;
                hold_next_s  = HOLD_BLOCKS;
            end else if (peak_s > TARGET_HI) begin
                gain_next_s  = (three_q_s < GAIN_MIN) ? GAIN_MIN : three_q_s;
                state_next_s = HOLD;
                hold_next_s  = HOLD_BLOCKS;
            end else begin
                case (state_r)
                    TRACK: begin
                        if ((peak_s < TARGET_LO) && (gain_r != GAIN_MAX)) begin
                            gain_next_s = gain_r + 8'd1;
                        end else begin
                            gain_next_s = gain_r;
                        end
                    end
                    HOLD: begin
                        hold_next_s = hold_r - 3'd1;
                        if (hold_r == 3'd1) begin
                            state_next_s = TRACK;
                        end else begin
                            state_next_s = HOLD;
                        end
                    end
                    default: begin
                        state_next_s = TRACK;
                        hold_next_s  = '0;
                    end
                endcase
            end
        end else begin
            gain_next_s = gain_r;
        end
    end

    assign bus.dout       = dout_r;
    assign bus.dout_valid = dout_valid_r;
    assign bus.gain       = gain_r;
    assign bus.clip       = clip_r;

`ifdef FM_AUDIO_PWM_EN
    logic pwm_s;
    fm_audio_sdm u_sdm (
        .clk   (clk),
        .rst_n (rst_n),
        .level ({~dout_r[DW-1], dout_r[DW-2:0]}),
        .pwm   (pwm_s)
    );
    assign bus.pwm_out = pwm_s;
`else
    assign bus.pwm_out = 1'b0;
`endif
endmodule
